// File: rtl/decode_issue_if.sv
// rtl/decode_issue_if.sv - fetch halfword handshake, register-file view and issue bundle
interface decode_issue_if;
    logic [15:0]       hw_i;
    logic              hw_valid_i;
    logic              hw_ready_o;
    logic [31:0][31:0] gr_i;
    logic              issue_o;
    logic [4:0]        destination_o;
    logic [31:0]       reg1_o;
    logic [31:0]       reg2_o;
    logic [4:0]        imm5_o;
    logic [2:0]        op_o;
    logic              illegal_o;

    modport slave (
        input  hw_i, hw_valid_i, gr_i,
        output hw_ready_o, issue_o, destination_o, reg1_o, reg2_o, imm5_o, op_o, illegal_o
    );

    modport master (
        output hw_i, hw_valid_i, gr_i,
        input  hw_ready_o, issue_o, destination_o, reg1_o, reg2_o, imm5_o, op_o, illegal_o
    );
endinterface

// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - V850 subset decode/operand fetch feeding an add-only executer
module decode_issue #(
    parameter logic [2:0] RESET_OP = 3'd0
) (
    input  logic          clk,
    input  logic          rst,
    decode_issue_if.slave bus
);
    typedef enum logic {S_FIRST, S_SECOND} state_t;

    localparam logic [5:0] OPC_MOV   = 6'b000000;
    localparam logic [5:0] OPC_ADD   = 6'b001110;
    localparam logic [5:0] OPC_MOVI5 = 6'b010000;
    localparam logic [5:0] OPC_ADDI5 = 6'b010010;
    localparam logic [5:0] OPC_ADDI  = 6'b110000;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_ADDI5 = 3'd2;
    localparam logic [2:0] OP_MOV   = 3'd3;
    localparam logic [2:0] OP_MOVI5 = 3'd4;
    localparam logic [2:0] OP_ADDI  = 3'd5;

    state_t      state_q, state_d;
    logic [4:0]  lat_reg1_q, lat_reg1_d, lat_reg2_q, lat_reg2_d;
    logic        lat_ill_q, lat_ill_d;
    logic        issue_q, issue_d, illegal_q, illegal_d;
    logic [4:0]  dest_q, dest_d, imm5_q, imm5_d;
    logic [31:0] reg1_q, reg1_d, reg2_q, reg2_d;
    logic [2:0]  op_q, op_d;

    logic [4:0]  f_reg1, f_reg2, src_a, src_b;
    logic [5:0]  f_opc;
    logic        src_a_use, src_b_use, hazard, accept;
    logic [31:0] f_sext5;

    function automatic logic [31:0] rd_gr(input logic [31:0][31:0] gr, input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : gr[idx];
    endfunction

    assign f_reg1  = bus.hw_i[4:0];
    assign f_reg2  = bus.hw_i[15:11];
    assign f_opc   = bus.hw_i[10:5];
    assign f_sext5 = {{27{f_reg1[4]}}, f_reg1};

    // The executer commits the issued result one edge later, so a source that
    // matches the in-flight destination must wait exactly one cycle.
    always_comb begin
        src_a     = 5'd0;
        src_b     = 5'd0;
        src_a_use = 1'b0;
        src_b_use = 1'b0;
        if (state_q == S_FIRST) begin
            case (f_opc)
                OPC_MOV:   begin src_a = f_reg1; src_a_use = 1'b1; end
                OPC_ADD:   begin src_a = f_reg1; src_a_use = 1'b1;
                                 src_b = f_reg2; src_b_use = 1'b1; end
                OPC_ADDI5: begin src_b = f_reg2; src_b_use = 1'b1; end
                default:   ;
            endcase
        end else if (!lat_ill_q) begin
            src_a     = lat_reg1_q;
            src_a_use = 1'b1;
        end
    end

    assign hazard = issue_q && (dest_q != 5'd0) &&
                    ((src_a_use && (src_a == dest_q)) || (src_b_use && (src_b == dest_q)));
    assign bus.hw_ready_o = !rst && !hazard;
    assign accept = bus.hw_valid_i && bus.hw_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FIRST;
            lat_reg1_q <= 5'd0;
            lat_reg2_q <= 5'd0;
            lat_ill_q  <= 1'b0;
            issue_q    <= 1'b0;
            illegal_q  <= 1'b0;
            dest_q     <= 5'd0;
            imm5_q     <= 5'd0;
            reg1_q     <= 32'd0;
            reg2_q     <= 32'd0;
            op_q       <= RESET_OP;
        end else begin
            state_q    <= state_d;
            lat_reg1_q <= lat_reg1_d;
            lat_reg2_q <= lat_reg2_d;
            lat_ill_q  <= lat_ill_d;
            issue_q    <= issue_d;
            illegal_q  <= illegal_d;
            dest_q     <= dest_d;
            imm5_q     <= imm5_d;
            reg1_q     <= reg1_d;
            reg2_q     <= reg2_d;
            op_q       <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lat_reg1_d = lat_reg1_q;
        lat_reg2_d = lat_reg2_q;
        lat_ill_d  = lat_ill_q;
        if (accept) begin
            if (state_q == S_FIRST) begin
                if (f_opc[5:4] == 2'b11) begin
                    state_d    = S_SECOND;
                    lat_reg1_d = f_reg1;
                    lat_reg2_d = f_reg2;
                    lat_ill_d  = (f_opc != OPC_ADDI);
                end
            end else begin
                state_d = S_FIRST;
            end
        end
    end

    always_comb begin
        issue_d   = 1'b0;
        illegal_d = 1'b0;
        dest_d    = dest_q;
        imm5_d    = imm5_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        op_d      = op_q;
        if (accept && state_q == S_FIRST) begin
            case (f_opc)
                OPC_MOV: begin
                    issue_d = 1'b1;
                    op_d    = (f_reg1 == 5'd0 && f_reg2 == 5'd0) ? OP_NOP : OP_MOV;
                    reg1_d  = rd_gr(bus.gr_i, f_reg1);
                    reg2_d  = 32'd0;
                    imm5_d  = 5'd0;
                    dest_d  = f_reg2;
                end
                OPC_ADD: begin
                    issue_d = 1'b1;
                    op_d    = OP_ADD;
                    reg1_d  = rd_gr(bus.gr_i, f_reg1);
                    reg2_d  = rd_gr(bus.gr_i, f_reg2);
                    imm5_d  = 5'd0;
                    dest_d  = f_reg2;
                end
                OPC_MOVI5: begin
                    issue_d = 1'b1;
                    op_d    = OP_MOVI5;
                    reg1_d  = f_sext5;
                    reg2_d  = 32'd0;
                    imm5_d  = f_reg1;
                    dest_d  = f_reg2;
                end
                OPC_ADDI5: begin
                    issue_d = 1'b1;
                    op_d    = OP_ADDI5;
                    reg1_d  = f_sext5;
                    reg2_d  = rd_gr(bus.gr_i, f_reg2);
                    imm5_d  = f_reg1;
                    dest_d  = f_reg2;
                end
                default: illegal_d = (f_opc[5:4] != 2'b11);
            endcase
        end else if (accept) begin
            if (lat_ill_q) begin
                illegal_d = 1'b1;
            end else begin
                issue_d = 1'b1;
                op_d    = OP_ADDI;
                reg1_d  = {{16{bus.hw_i[15]}}, bus.hw_i};
                reg2_d  = rd_gr(bus.gr_i, lat_reg1_q);
                imm5_d  = 5'd0;
                dest_d  = lat_reg2_q;
            end
        end
    end

    assign bus.issue_o       = issue_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.destination_o = dest_q;
    assign bus.reg1_o        = reg1_q;
    assign bus.reg2_o        = reg2_q;
    assign bus.imm5_o        = imm5_q;
    assign bus.op_o          = op_q;
endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/operand-fetch stage placed directly upstream of the executer.
- Accepts V850 instruction halfwords from fetch and assembles 32-bit formats.
- Decodes a supported subset, reads operands from the executer's general-register array and issues one registered operand bundle per instruction.
- The executer adds reg1 and reg2 and writes the result to the destination register. Every supported instruction is therefore mapped onto that add.

Parameters:
- RESET_OP, 3'd0, op_o value driven during reset and idle (NOP).

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- hw_i  input  16  instruction halfword from fetch
- hw_valid_i  input  1  hw_i is valid this cycle
- hw_ready_o  output  1  stage accepts hw_i this cycle (combinational)
- gr_i  input  32x32  executer general registers; gr_i[n] is rn
- issue_o  output  1  one-cycle strobe: the operand bundle is valid
- destination_o  output  5  destination register number
- reg1_o  output  32  first adder operand
- reg2_o  output  32  second adder operand
- imm5_o  output  5  raw imm5 field; 0 for non-imm5 formats
- op_o  output  3  0 NOP, 1 ADD, 2 ADD-imm5, 3 MOV, 4 MOV-imm5, 5 ADDI
- illegal_o  output  1  one-cycle strobe: unsupported opcode consumed

Behaviour:
- Handshake: a halfword is accepted at a rising edge when hw_valid_i && hw_ready_o.
- Field split of the first halfword: reg2 = hw[15:11], opcode = hw[10:5], reg1/imm5 = hw[4:0].
- Register reads: r0 reads as 0 regardless of gr_i[0]. sext(x) means sign-extension to 32 bits.
- Decode table (first halfword):
  - 000000 MOV: reg1_o = GR[reg1], reg2_o = 0. If reg1 = reg2 = 0, op = NOP instead.
  - 001110 ADD: reg1_o = GR[reg1], reg2_o = GR[reg2].
  - 010000 MOV-imm5: reg1_o = sext(imm5), reg2_o = 0.
  - 010010 ADD-imm5: reg1_o = sext(imm5), reg2_o = GR[reg2].
  - 110000 ADDI: 32-bit instruction; reg1_o = sext(second halfword), reg2_o = GR[reg1].
  - destination_o = reg2 in all cases.
  - Any other opcode with hw[10:9] != 2'b11: illegal, 16-bit.
  - Any other opcode with hw[10:9] == 2'b11: illegal, 32-bit; the second halfword is consumed and discarded.
- FSM states:
  - S_FIRST: accepting a first halfword. A 16-bit instruction issues at the accept edge. A 32-bit instruction moves to S_SECOND and latches reg1, reg2 and the illegal flag.
  - S_SECOND: the accepted halfword completes the instruction. Issue (or illegal) happens at that edge; return to S_FIRST.
- Latency:
  - Outputs are registered; the bundle and issue_o are valid in the cycle after the final accepted halfword.
  - issue_o and illegal_o are high for exactly 1 cycle and never both.
  - Bundle outputs hold their last value when issue_o is low.
- RAW hazard: the executer writes GR one edge after issue.
  - While issue_o = 1 and destination_o != 0, hw_ready_o = 0 if a GR source of the pending accept equals destination_o.
  - Pending-accept sources: reg1/reg2 as used by the decoded op in S_FIRST; the latched reg1 for ADDI in S_SECOND.
  - This stall lasts exactly 1 cycle. The next cycle accepts with the updated gr_i.
- hw_ready_o = 1 whenever there is no hazard, including during reset release.
- Illegal instructions never stall.
- Reset, including mid-S_SECOND:
  - State returns to S_FIRST and any partial instruction is dropped.
  - issue_o = 0, illegal_o = 0, op_o = RESET_OP, destination_o = 0, reg1_o = 0, reg2_o = 0, imm5_o = 0.
  - hw_ready_o = 0 while rst = 1.
- hw_valid_i low in S_SECOND: stay in S_SECOND indefinitely with no timeout.

Test Plan:
- GR1 = 5, GR2 = 7; accept 0x11C1 (ADD r1,r2) -> next cycle issue_o = 1, op_o = 1, reg1_o = 5, reg2_o = 7, destination_o = 2.
- Accept 0x1A1D (MOV -3,r3) -> issue_o = 1, op_o = 4, reg1_o = 0xFFFFFFFD, reg2_o = 0, imm5_o = 0x1D, destination_o = 3.
- GR4 = 0x10; accept 0x2E04 then 0x8000 (ADDI 0x8000,r4,r5):
  - no issue after the first halfword;
  - after the second: op_o = 5, reg1_o = 0xFFFF8000, reg2_o = 0x10, destination_o = 5.
- Back-to-back 0x11C1 then 0x19C2 (ADD r2,r3) with hw_valid_i held high:
  - hw_ready_o is low exactly 1 cycle after the first issue;
  - the second issue comes 2 cycles after the first, with reg1_o equal to the updated GR2.
- Accept 0x0020 (opcode 000001) -> illegal_o pulses 1 cycle, issue_o stays 0, no stall; 0x0000 -> issue_o = 1, op_o = 0.
- Accept 0x2E04, assert rst for 1 cycle, then accept 0x11C1:
  - all outputs are at their reset values during reset;
  - 0x11C1 decodes as a 16-bit ADD, not as an ADDI second halfword.
